// File: rtl/fetch_sequencer.sv
// fetch_sequencer: walks a byte-wide big-endian instruction memory four
// bytes at a time and presents whole 32-bit instructions to decode over a
// valid/ready handshake. Branch/jump redirects restart the fetch; an
// unaligned or out-of-range target parks the block in a sticky fault.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int          MEM_BYTES = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        fault
);

   typedef enum logic [2:0] {
      F0    = 3'd0,
      F1    = 3'd1,
      F2    = 3'd2,
      F3    = 3'd3,
      HOLD  = 3'd4,
      FAULT = 3'd5
   } state_t;

   // Highest address at which a whole instruction still fits.
   localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [23:0] shreg_q, shreg_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic        target_ok;
   logic [31:0] byte_offset;

   // Memory-side outputs depend on state and fetch_pc only, so no input
   // can ever combinationally reach the memory address.
   always_comb begin
      byte_offset = 32'd0;
      mem_rd      = 1'b0;
      case (state_q)
         F0:      begin byte_offset = 32'd0; mem_rd = 1'b1; end
         F1:      begin byte_offset = 32'd1; mem_rd = 1'b1; end
         F2:      begin byte_offset = 32'd2; mem_rd = 1'b1; end
         F3:      begin byte_offset = 32'd3; mem_rd = 1'b1; end
         default: begin byte_offset = 32'd0; mem_rd = 1'b0; end
      endcase
      mem_addr = fetch_pc_q + byte_offset;
   end

   // Next-state logic: byte capture and handshake first, redirect overrides.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      shreg_d    = shreg_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      fault_d    = fault_q;
      target_ok  = (redirect_target[1:0] == 2'b00) && (redirect_target <= LAST_ADDR);

      case (state_q)
         F0: begin
            shreg_d[23:16] = mem_data;
            state_d        = F1;
         end
         F1: begin
            shreg_d[15:8] = mem_data;
            state_d       = F2;
         end
         F2: begin
            shreg_d[7:0] = mem_data;
            state_d      = F3;
         end
         F3: begin
            instr_d    = {shreg_q, mem_data};
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            // Compare instead of modulo so non-power-of-two sizes wrap too.
            fetch_pc_d = (fetch_pc_q == LAST_ADDR) ? 32'd0 : fetch_pc_q + 32'd4;
            state_d    = HOLD;
         end
         HOLD: begin
            if (instr_ready) begin
               valid_d = 1'b0;
               state_d = F0;
            end
         end
         FAULT: begin
            valid_d = 1'b0;
         end
         default: begin
            state_d = FAULT;
            valid_d = 1'b0;
            fault_d = 1'b1;
         end
      endcase

      // A redirect wins over everything; a held instruction accepted in the
      // same cycle is simply consumed, partial bytes are thrown away.
      if (redirect && (state_q != FAULT)) begin
         instr_d = instr_q;
         pc_d    = pc_q;
         shreg_d = shreg_q;
         valid_d = 1'b0;
         if (target_ok) begin
            fetch_pc_d = redirect_target;
            state_d    = F0;
         end else begin
            fetch_pc_d = fetch_pc_q;
            fault_d    = 1'b1;
            state_d    = FAULT;
         end
      end
   end

   // State and registered outputs; reset drops any in-flight or held data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= F0;
         fetch_pc_q <= RESET_PC;
         shreg_q    <= 24'd0;
         instr_q    <= 32'd0;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         shreg_q    <= shreg_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
      end
   end

   assign instr       = instr_q;
   assign pc          = pc_q;
   assign instr_valid = valid_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte memory model, expected instructions queued
// as stimulus is set up and popped when the DUT completes a transfer.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic        fault;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t     exp_q[$];
   logic [7:0] tb_mem [0:31];
   int       total = 0;
   int       bad = 0;

   fetch_sequencer #(.RESET_PC(32'd0), .MEM_BYTES(32)) dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data(mem_data), .instr(instr), .pc(pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect(redirect),
      .redirect_target(redirect_target), .fault(fault)
   );

   always #5 clk = ~clk;

   assign mem_data = (mem_addr < 32'd32) ? tb_mem[mem_addr[4:0]] : 8'h00;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {tb_mem[a[4:0]], tb_mem[a[4:0] + 5'd1], tb_mem[a[4:0] + 5'd2], tb_mem[a[4:0] + 5'd3]};
   endfunction

   function automatic exp_t mk(input logic [31:0] a);
      exp_t e;
      e.pc    = a;
      e.instr = mem_word(a);
      return e;
   endfunction

   // Advance to the middle of the next cycle (sample/drive point).
   task automatic tick();
      @(negedge clk);
   endtask

   // One reset edge; returns at the negedge of cycle 0.
   task automatic do_reset();
      reset    = 1'b1;
      redirect = 1'b0;
      exp_q.delete();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({instr_valid, fault, mem_rd} !== 3'b001 || instr !== 32'd0 || pc !== 32'd0 || mem_addr !== 32'd0) begin
         bad++;
         $display("FAIL reset: valid=%b fault=%b rd=%b instr=%h pc=%h addr=%h, need 0 0 1 0 0 0",
                  instr_valid, fault, mem_rd, instr, pc, mem_addr);
      end
      $display("reset: valid=%b fault=%b rd=%b addr=%h", instr_valid, fault, mem_rd, mem_addr);
   endtask

   task automatic test_sequential();
      exp_t e;
      do_reset();
      instr_ready = 1'b1;
      exp_q.push_back(mk(32'd0));
      exp_q.push_back(mk(32'd4));
      for (int c = 0; c <= 9; c++) begin
         if (c <= 3) begin
            total++;
            if (mem_addr !== 32'(c) || mem_rd !== 1'b1) begin
               bad++;
               $display("FAIL seq_addr c%0d: addr=%h rd=%b, need %h 1", c, mem_addr, mem_rd, c);
            end
         end
         total++;
         if (instr_valid !== (c == 4 || c == 9)) begin
            bad++;
            $display("FAIL seq_valid c%0d: valid=%b, need %b", c, instr_valid, (c == 4 || c == 9));
         end else if (instr_valid) begin
            e = exp_q.pop_front();
            total++;
            if (instr !== e.instr || pc !== e.pc) begin
               bad++;
               $display("FAIL seq_data c%0d: instr=%h pc=%h, need %h %h", c, instr, pc, e.instr, e.pc);
            end
            $display("seq: cycle %0d instr=%h pc=%h", c, instr, pc);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      do_reset();
      instr_ready = 1'b0;
      exp_q.push_back(mk(32'd0));
      repeat (4) tick();
      for (int c = 4; c <= 13; c++) begin
         total++;
         if (instr_valid !== 1'b1 || instr !== 32'h8C0E0000 || pc !== 32'd0 || mem_rd !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold c%0d: valid=%b instr=%h pc=%h rd=%b, need 1 8c0e0000 0 0",
                     c, instr_valid, instr, pc, mem_rd);
         end
         tick();
      end
      instr_ready = 1'b1;
      e = exp_q.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc) begin
         bad++;
         $display("FAIL bp_xfer: valid=%b instr=%h pc=%h, need 1 %h %h", instr_valid, instr, pc, e.instr, e.pc);
      end
      $display("bp: cycle 14 transfer instr=%h pc=%h", instr, pc);
      tick();
      total++;
      if (mem_addr !== 32'd4 || mem_rd !== 1'b1 || instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_resume: addr=%h rd=%b valid=%b, need 4 1 0", mem_addr, mem_rd, instr_valid);
      end
   endtask

   task automatic test_redirect();
      exp_t e;
      do_reset();
      instr_ready = 1'b1;
      tick();
      tick();
      redirect        = 1'b1;
      redirect_target = 32'd4;
      tick();
      redirect = 1'b0;
      exp_q.push_back(mk(32'd4));
      total++;
      if (mem_addr !== 32'd4 || mem_rd !== 1'b1) begin
         bad++;
         $display("FAIL redir_addr: addr=%h rd=%b, need 4 1", mem_addr, mem_rd);
      end
      for (int c = 3; c <= 7; c++) begin
         total++;
         if (instr_valid !== (c == 7)) begin
            bad++;
            $display("FAIL redir_valid c%0d: valid=%b, need %b", c, instr_valid, (c == 7));
         end else if (instr_valid) begin
            e = exp_q.pop_front();
            total++;
            if (instr !== e.instr || pc !== e.pc) begin
               bad++;
               $display("FAIL redir_data: instr=%h pc=%h, need %h %h", instr, pc, e.instr, e.pc);
            end
            $display("redir: cycle %0d instr=%h pc=%h", c, instr, pc);
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      do_reset();
      instr_ready     = 1'b1;
      redirect        = 1'b1;
      redirect_target = 32'd28;
      tick();
      redirect = 1'b0;
      exp_q.push_back(mk(32'd28));
      exp_q.push_back(mk(32'd0));
      for (int c = 1; c <= 10; c++) begin
         total++;
         if (fault !== 1'b0) begin
            bad++;
            $display("FAIL wrap_fault c%0d: fault=%b, need 0", c, fault);
         end
         if (c == 6) begin
            total++;
            if (mem_addr !== 32'd0 || mem_rd !== 1'b1) begin
               bad++;
               $display("FAIL wrap_addr: addr=%h rd=%b, need 0 1", mem_addr, mem_rd);
            end
         end
         if (instr_valid) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL wrap_extra c%0d: instr=%h pc=%h, need no transfer", c, instr, pc);
            end else begin
               e = exp_q.pop_front();
               if (instr !== e.instr || pc !== e.pc) begin
                  bad++;
                  $display("FAIL wrap_data c%0d: instr=%h pc=%h, need %h %h", c, instr, pc, e.instr, e.pc);
               end
               $display("wrap: cycle %0d instr=%h pc=%h", c, instr, pc);
            end
         end
         tick();
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL wrap_count: left=%0d, need 0", exp_q.size());
      end
   endtask

   task automatic test_fault(input logic [31:0] target);
      do_reset();
      instr_ready     = 1'b1;
      redirect        = 1'b1;
      redirect_target = target;
      tick();
      redirect = 1'b0;
      for (int c = 0; c < 6; c++) begin
         total++;
         if (fault !== 1'b1 || instr_valid !== 1'b0 || mem_rd !== 1'b0) begin
            bad++;
            $display("FAIL fault_%0d c%0d: fault=%b valid=%b rd=%b, need 1 0 0", target, c, fault, instr_valid, mem_rd);
         end
         tick();
      end
      $display("fault: target %0d fault=%b", target, fault);
      do_reset();
      total++;
      if (fault !== 1'b0 || mem_addr !== 32'd0 || mem_rd !== 1'b1) begin
         bad++;
         $display("FAIL fault_clear_%0d: fault=%b addr=%h rd=%b, need 0 0 1", target, fault, mem_addr, mem_rd);
      end
      repeat (4) tick();
      total++;
      if (instr_valid !== 1'b1 || instr !== 32'h8C0E0000 || pc !== 32'd0) begin
         bad++;
         $display("FAIL fault_refetch_%0d: valid=%b instr=%h pc=%h, need 1 8c0e0000 0", target, instr_valid, instr, pc);
      end
   endtask

   task automatic test_hold_redirect();
      exp_t e;
      do_reset();
      instr_ready = 1'b0;
      exp_q.push_back(mk(32'd0));
      repeat (6) tick();
      instr_ready     = 1'b1;
      redirect        = 1'b1;
      redirect_target = 32'd4;
      e = exp_q.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc) begin
         bad++;
         $display("FAIL hr_held: valid=%b instr=%h pc=%h, need 1 %h %h", instr_valid, instr, pc, e.instr, e.pc);
      end
      exp_q.push_back(mk(32'd4));
      tick();
      redirect = 1'b0;
      total++;
      if (instr_valid !== 1'b0 || mem_addr !== 32'd4 || fault !== 1'b0) begin
         bad++;
         $display("FAIL hr_restart: valid=%b addr=%h fault=%b, need 0 4 0", instr_valid, mem_addr, fault);
      end
      repeat (4) tick();
      e = exp_q.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc) begin
         bad++;
         $display("FAIL hr_data: valid=%b instr=%h pc=%h, need 1 %h %h", instr_valid, instr, pc, e.instr, e.pc);
      end
      $display("hold_redirect: instr=%h pc=%h", instr, pc);
   endtask

   task automatic test_reset_mid();
      exp_t e;
      do_reset();
      instr_ready = 1'b1;
      repeat (7) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.push_back(mk(32'd0));
      total++;
      if (instr_valid !== 1'b0 || mem_addr !== 32'd0 || fault !== 1'b0) begin
         bad++;
         $display("FAIL rmid_state: valid=%b addr=%h fault=%b, need 0 0 0", instr_valid, mem_addr, fault);
      end
      for (int c = 0; c <= 4; c++) begin
         total++;
         if (c <= 3 && (mem_addr !== 32'(c) || instr_valid !== 1'b0)) begin
            bad++;
            $display("FAIL rmid_addr c%0d: addr=%h valid=%b, need %h 0", c, mem_addr, instr_valid, c);
         end else if (c == 4) begin
            e = exp_q.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc) begin
               bad++;
               $display("FAIL rmid_data: valid=%b instr=%h pc=%h, need 1 %h %h", instr_valid, instr, pc, e.instr, e.pc);
            end
            $display("reset_mid: instr=%h pc=%h", instr, pc);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic        prev_valid;
      logic        prev_xfer;
      logic [31:0] prev_instr;
      logic [31:0] prev_pc;
      int          n_xfer;
      do_reset();
      for (int i = 0; i < 16; i++) exp_q.push_back(mk(32'((4 * i) % 32)));
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
      prev_instr = 32'd0;
      prev_pc    = 32'd0;
      n_xfer     = 0;
      for (int c = 0; c < 60; c++) begin
         instr_ready = (c % 3) != 0;
         if (instr_valid && prev_valid && !prev_xfer) begin
            total++;
            if (instr !== prev_instr || pc !== prev_pc) begin
               bad++;
               $display("FAIL b2b_stable c%0d: instr=%h pc=%h, need %h %h", c, instr, pc, prev_instr, prev_pc);
            end
         end
         if (instr_valid && instr_ready) begin
            e = exp_q.pop_front();
            n_xfer++;
            total++;
            if (instr !== e.instr || pc !== e.pc) begin
               bad++;
               $display("FAIL b2b_data c%0d: instr=%h pc=%h, need %h %h", c, instr, pc, e.instr, e.pc);
            end
            $display("b2b: cycle %0d instr=%h pc=%h", c, instr, pc);
         end
         prev_valid = instr_valid;
         prev_xfer  = instr_valid && instr_ready;
         prev_instr = instr;
         prev_pc    = pc;
         tick();
      end
      total++;
      if (n_xfer < 6) begin
         bad++;
         $display("FAIL b2b_count: transfers=%0d, need >= 6", n_xfer);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) tb_mem[i] = 8'h00;
      tb_mem[0] = 8'h8C; tb_mem[1] = 8'h0E; tb_mem[2] = 8'h00; tb_mem[3] = 8'h00;
      tb_mem[4] = 8'h8C; tb_mem[5] = 8'h0F; tb_mem[6] = 8'h00; tb_mem[7] = 8'h04;
      tick();
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_fault(32'd6);
      test_fault(32'd32);
      test_hold_redirect();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the byte-wide, big-endian instruction memory into whole 32-bit instructions for the core.
- Owns the fetch PC and issues four byte reads per instruction: address, address+1, address+2, address+3, with byte 0 being the MSB.
- Assembles the result and presents it to the decode stage over a valid/ready handshake.
- Accepts branch/jump redirects.
- Sits between the instruction memory and decode, replacing direct PC-to-memory wiring.

## Interface

- `RESET_PC`, default 0: fetch address loaded on reset. Must be 4-aligned.
- `MEM_BYTES`, default 32: instruction memory size in bytes. Multiple of 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_addr`  out  32  byte address to instruction memory.
- `mem_rd`  out  1  read strobe; high only in the FETCH states.
- `mem_data`  in  8  byte returned by memory; combinational, valid in the same cycle as `mem_addr`.
- `instr`  out  32  assembled instruction, registered.
- `pc`  out  32  address of the instruction held on `instr`, registered.
- `instr_valid`  out  1  `instr`/`pc` hold a fetched instruction.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `redirect`  in  1  abort current fetch and restart at `redirect_target`.
- `redirect_target`  in  32  new fetch address.
- `fault`  out  1  sticky: illegal redirect target seen.

## Operation

- **States:** F0, F1, F2, F3, HOLD, FAULT.
- **Internal registers:** `fetch_pc` (32), `shreg` (24, bytes 0-2).
- **F0-F3:**
  - `mem_addr` = `fetch_pc` + k, `mem_rd` = 1.
  - At the edge, `mem_data` is stored as byte k.
  - F3 additionally loads `instr` = {b0, b1, b2, mem_data} and `pc` = `fetch_pc`, and sets `instr_valid`.
  - `fetch_pc` advances to (`fetch_pc` + 4) mod `MEM_BYTES`, and the state goes to HOLD.
- **HOLD:**
  - `mem_rd` = 0; `mem_addr` = `fetch_pc` (don't-care for memory).
  - `instr_valid` = 1 and `instr`/`pc` stay stable.
  - On an edge with `instr_ready` = 1: clear `instr_valid` and go to F0.
  - Otherwise stay in HOLD.
- **Redirect, any state except FAULT:**
  - Takes priority over the handshake and over byte capture.
  - If `redirect_target`[1:0] == 0 and `redirect_target` ≤ `MEM_BYTES` − 4: set `fetch_pc` = `redirect_target`, clear `instr_valid`, go to F0. Partially fetched bytes are discarded.
  - Otherwise: `fault` = 1, `instr_valid` = 0, go to FAULT.
- **HOLD with both `instr_ready` and a legal `redirect`:** the held instruction counts as consumed, then the redirect applies.
- **FAULT:** `mem_rd` = 0, `instr_valid` = 0. Exited only by reset.
- **Wrap-around:** the sequential fetch after address `MEM_BYTES` − 4 continues at 0. This is not a fault.
- **Reset values, after the reset edge:**
  - state F0, `fetch_pc` = `RESET_PC`
  - `mem_addr` = `RESET_PC`, `mem_rd` = 1
  - `instr` = 0, `pc` = `RESET_PC`, `instr_valid` = 0, `fault` = 0
- **Reset mid-operation:** discards all in-flight bytes and any held instruction in any state.

## Timing

- **Cycle numbering:** cycle 0 is the first cycle after `reset` is sampled low, and the block is in F0.
- **Latency:**
  - Bytes are captured at the ends of cycles 0-3.
  - `instr_valid` rises in cycle 4.
- **Throughput:** with `instr_ready` held high, one instruction every 5 cycles. `instr_valid` is high in cycles 4, 9, 14, …
- **Redirect:** a redirect sampled at the end of cycle n gives F0 at the new target in cycle n+1, and valid data in cycle n+5.
- **Handshake:**
  - A transfer occurs on an edge where `instr_valid` & `instr_ready`.
  - `instr_ready` may toggle freely.
  - `instr`/`pc` never change while `instr_valid` = 1 without a transfer or redirect.
- **Outputs:** `mem_addr` and `mem_rd` are combinational from state and `fetch_pc` only, never from inputs. All other outputs are registered.

## Test plan

Memory preloaded: bytes 0-7 = 8C 0E 00 00 8C 0F 00 04, all others 00.

- **Sequential fetch:** reset, `instr_ready` = 1 → `mem_addr` 0, 1, 2, 3 in cycles 0-3. Cycle 4: `instr` = 8C0E0000, `pc` = 0. Cycle 9: `instr` = 8C0F0004, `pc` = 4.
- **Backpressure:** `instr_ready` = 0 for cycles 4-13 → `instr` stays 8C0E0000, `mem_rd` = 0 throughout. `instr_ready` = 1 in cycle 14 → F0 at address 4 in cycle 15.
- **Redirect mid-fetch:** `redirect` = 1, target 4, in cycle 2 → cycle 3 `mem_addr` = 4. Cycle 7: `instr` = 8C0F0004, `pc` = 4. The instruction at 0 is never presented.
- **Wrap:** redirect to 28, `instr_ready` = 1 → `pc` = 28 presented, then the next F0 has `mem_addr` = 0, `fault` stays 0, next `instr` = 8C0E0000.
- **Fault:**
  - Redirect to 6 → next cycle `fault` = 1, `instr_valid` = 0, `mem_rd` = 0, held until reset. Reset clears it and refetch starts at 0.
  - Repeat with target 32 → same fault response.
- **Reset mid-operation:** assert reset in F2 of the second fetch → after reset, `instr_valid` = 0, `mem_addr` = 0, and the sequence matches the sequential-fetch scenario.
